conv_window_builder: RTL
========================

// Module: conv_window_builder
// PURPOSE
//  Upstream feeder for the 5x5 convolution datapath (multiplier array + adder tree).
//  Accepts a raster-scan 8-bit grayscale pixel stream, buffers the last K-1 rows, and emits every
//  valid KxK window as one packed 200-bit word. The packing is the word the multiplier array
//  consumes: byte k pairs with kernel coefficient k.
//  Removes the need for the datapath to read 25 bytes per window from VRAM.
// PARAMETERS
//  IMG_W   200  image width in pixels (>= K)
//  IMG_H   200  image height in pixels (>= K)
//  K       5    kernel side; the window is K*K pixels
//  PIX_W   8    bits per pixel
// PORTS
//  clk        in   1             rising-edge clock
//  rst        in   1             synchronous reset, active-high
//  pix_in     in   PIX_W         input pixel, raster order: row 0 first, col 0 first
//  pix_valid  in   1             pix_in is valid
//  pix_ready  out  1             block accepts pix_in this cycle
//  win_data   out  K*K*PIX_W     window; byte k=r*K+c at [8k+7:8k], r=0 oldest row, c=0 leftmost col
//  win_valid  out  1             win_data is valid
//  win_ready  in   1             consumer takes win_data this cycle
//  frame_done out  1             one-cycle pulse after the last pixel of a frame is accepted
// BEHAVIOUR
//  - Interface: one clock (clk); reset is synchronous and active-high (rst).
//  - Reset values: win_valid=0, frame_done=0, pix_ready=1, win_data=0.
//    Row/col counters and the window register are cleared. Line-buffer RAM contents are not cleared.
//  - Accept: a pixel is accepted when pix_valid && pix_ready, with pix_ready = !win_valid || win_ready.
//    This is a single output register with no skid buffer.
//  - Per accepted pixel at (row,col):
//    - Read column col of the K-1 line-buffer rows. Form a K-tall column: the K-1 old pixels, then pix_in as the bottom entry.
//    - Shift this column into the KxK window register at c=K-1; the oldest column drops out.
//    - Write the column back to the line buffer shifted up by one row, dropping the oldest row.
//  - Output: when row>=K-1 && col>=K-1, load win_data and set win_valid on the next edge (latency 1 cycle).
//    win_valid clears on win_ready when no new window is loaded.
//    A simultaneous take and new load keeps win_valid=1.
//  - Stability: win_data and win_valid are held stable while win_valid && !win_ready.
//  - Counters:
//    - col wraps IMG_W-1 -> 0 and then increments row.
//    - row wraps IMG_H-1 -> 0 (the frame ends).
//    - frame_done pulses on the edge after the pixel at (IMG_H-1, IMG_W-1) is accepted.
//  - Window count: (IMG_W-K+1)*(IMG_H-K+1) windows per frame; 196*196 = 38416 at the defaults.
//  - No wrap artifacts: at col<K-1 the window holds stale columns from the previous row.
//    No window is emitted there, so no window ever spans two rows or two frames.
//  - Back-to-back frames: no idle cycle is required between frames. Stale line-buffer data from the
//    previous frame is never output, because rows < K-1 produce no window.
//  - Reset mid-frame: any in-flight window is discarded (win_valid=0) and the next pixel is treated as (0,0).
//  - Arithmetic: counters are $clog2(IMG_W) and $clog2(IMG_H) bits wide and compared with == against W-1 and H-1.
//    There is no arithmetic on pixel data.
// STRUCTURE
//  - Shared include conv_defs.vh holds:
//    - constants K, PIX_W, WIN_W = K*K*PIX_W;
//    - default IMG_W and IMG_H;
//    - a macro WIN_BYTE(k) giving the byte slice [8k+7:8k].
//  - One sub-module, conv_line_buffer: simple dual-port RAM, IMG_W deep, (K-1)*PIX_W wide.
//    - Synchronous write, combinational (async) read at the same address, so the read-modify-write completes in 1 cycle.
//  - The top level holds the counters, the window shift register, the output register and handshake, and the frame_done logic.
// TESTING (bench uses IMG_W=IMG_H=8, K=5; ramp pixel p(r,c) = r*8+c)
//  1. Assert rst for 2 cycles, hold pix_valid=0 -> win_valid=0, frame_done=0, pix_ready=1.
//  2. Stream the ramp with win_ready=1 -> the first win_valid appears 1 cycle after p(4,4) is accepted.
//     Expected win_data bytes: [7:0]=0x00, [39:32]=0x04, [199:192]=0x24.
//  3. Full frame, win_ready=1 -> exactly 16 windows. The last window has [7:0]=0x1B and [199:192]=0x3F.
//     frame_done is high exactly once, on the cycle after p(7,7) is accepted.
//  4. Hold win_ready=0 for 10 cycles while windows are pending.
//     Required: pix_ready=0 and win_data stable throughout. After release, the 16 windows match test 2/3 in order, with none lost or duplicated.
//  5. Pulse rst after 20 accepted pixels, then stream a full frame -> output identical to tests 2/3, with no window emitted before p(4,4).
//  6. Two frames back-to-back with continuous pix_valid, frame 2 = ramp+0x40.
//     Required: 32 windows in total; the first window of frame 2 has [7:0]=0x40; two frame_done pulses.

Source files
------------

// File: rtl/conv_window_builder_pkg.sv
// Shared constants for the KxK convolution window builder and its line buffer.
package conv_window_builder_pkg;

    localparam int K_DEF     = 5;
    localparam int PIX_W_DEF = 8;
    localparam int WIN_W_DEF = K_DEF * K_DEF * PIX_W_DEF;
    localparam int IMG_W_DEF = 200;
    localparam int IMG_H_DEF = 200;

    // Bit offset of window byte k = r*K + c in the packed word the multiplier array consumes.
    function automatic int win_lsb(input int r, input int c, input int k, input int pix_w);
        return (r * k + c) * pix_w;
    endfunction

endpackage

// File: rtl/conv_window_builder_line_buffer.sv
// Line buffer holding the last K-1 rows: synchronous write, combinational read,
// so one read-modify-write per accepted pixel completes in a single cycle.
module conv_line_buffer
    import conv_window_builder_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF,
    parameter int WIDTH = (K_DEF - 1) * PIX_W_DEF
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    // Contents are deliberately not reset; stale rows are never emitted.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/conv_window_builder.sv
// Builds every valid KxK window from a raster pixel stream and presents it as one
// packed word behind a single-register valid/ready output stage.
module conv_window_builder
    import conv_window_builder_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int K     = K_DEF,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PIX_W-1:0]       pix_in,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    output logic [K*K*PIX_W-1:0]   win_data,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic                   frame_done
);

    localparam int WIN_W = K * K * PIX_W;
    localparam int LB_W  = (K - 1) * PIX_W;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [WIN_W-1:0] win_q, win_d, win_data_q;
    logic             win_valid_q, frame_done_q;
    logic [LB_W-1:0]  lb_rd, lb_wr;
    logic [PIX_W-1:0] col_pix [K];
    logic             accept, last_col, last_row, emit;

    assign pix_ready = !win_valid_q || win_ready;
    assign accept    = pix_valid && pix_ready;
    assign last_col  = (col_q == CW'(IMG_W - 1));
    assign last_row  = (row_q == RW'(IMG_H - 1));
    assign emit      = accept && (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));

    conv_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (LB_W)
    ) u_line_buffer (
        .clk     (clk),
        .we_i    (accept),
        .waddr_i (col_q),
        .wdata_i (lb_wr),
        .raddr_i (col_q),
        .rdata_o (lb_rd)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Column = K-1 buffered pixels (oldest first) with the new pixel at the bottom;
    // it enters the window at c=K-1 and goes back to the buffer one row higher.
    always_comb begin
        col_pix = '{default: '0};
        lb_wr   = '0;
        win_d   = win_q;
        for (int r = 0; r < K - 1; r++) begin
            col_pix[r] = lb_rd[r*PIX_W +: PIX_W];
        end
        col_pix[K-1] = pix_in;
        for (int j = 0; j < K - 1; j++) begin
            lb_wr[j*PIX_W +: PIX_W] = col_pix[j+1];
        end
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_d[win_lsb(r, c, K, PIX_W) +: PIX_W] = win_q[win_lsb(r, c + 1, K, PIX_W) +: PIX_W];
            end
            win_d[win_lsb(r, K - 1, K, PIX_W) +: PIX_W] = col_pix[r];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_data_q   <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= accept && last_col && last_row;
            if (accept) begin
                win_q <= win_d;
            end
            if (emit) begin
                win_data_q  <= win_d;
                win_valid_q <= 1'b1;
            end else if (win_ready) begin
                win_valid_q <= 1'b0;
            end
        end
    end

    assign win_data   = win_data_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

endmodule
